rf_scoreboard: RTL

//  Register-file hazard controller for the 8 x 16-bit register file. Tracks in-flight writes per

---
 rtl/rf_scoreboard_pkg.sv | 26 ++
 rtl/rf_scoreboard_if.sv | 35 +++
 rtl/rf_sb_counter.sv | 46 ++++
 rtl/rf_scoreboard.sv | 123 ++++++++++++
 4 files changed

// File: rtl/rf_scoreboard_pkg.sv
// Shared constants, instruction field positions and FSM encoding for the
// register-file scoreboard.
package rf_scoreboard_pkg;

    localparam int NREG   = 8;
    localparam int SELW   = 3;

    localparam int RA_MSB = 13;
    localparam int RA_LSB = 11;
    localparam int RB_MSB = 10;
    localparam int RB_LSB = 8;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sb_state_e;

    function automatic logic [SELW-1:0] ra_field(input logic [15:0] ir);
        return ir[RA_MSB:RA_LSB];
    endfunction

    function automatic logic [SELW-1:0] rb_field(input logic [15:0] ir);
        return ir[RB_MSB:RB_LSB];
    endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// Issue / writeback / drain signal bundle between the pipeline (master) and
// the scoreboard (slave).
interface rf_scoreboard_if;
    import rf_scoreboard_pkg::*;

    logic            issue_valid;
    logic [15:0]     from_ir;
    logic            use_ra;
    logic            use_rb;
    logic            wr_en;
    logic [SELW-1:0] wr_sel;
    logic            issue_ack;
    logic            stall;
    logic            fwd_ra;
    logic            fwd_rb;
    logic            wb_valid;
    logic [SELW-1:0] wb_sel;
    logic [NREG-1:0] busy_mask;
    logic            drain_req;
    logic            drain_done;
    logic            wb_err;

    modport master (
        output issue_valid, from_ir, use_ra, use_rb, wr_en, wr_sel,
        output wb_valid, wb_sel, drain_req,
        input  issue_ack, stall, fwd_ra, fwd_rb, busy_mask, drain_done, wb_err
    );

    modport slave (
        input  issue_valid, from_ir, use_ra, use_rb, wr_en, wr_sel,
        input  wb_valid, wb_sel, drain_req,
        output issue_ack, stall, fwd_ra, fwd_rb, busy_mask, drain_done, wb_err
    );

endinterface

// File: rtl/rf_sb_counter.sv
// Outstanding-write counter for one register. Increment at max and decrement
// at zero are both suppressed so the count never wraps.
module rf_sb_counter #(
    parameter int CNTW = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic is_zero,
    output logic is_one,
    output logic is_max,
    output logic next_zero
);

    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_next;
    logic            dec_ok;

    assign is_zero = (cnt == '0);
    assign is_one  = (cnt == CNTW'(1));
    assign is_max  = (cnt == {CNTW{1'b1}});
    assign dec_ok  = dec & ~is_zero;

    // Simultaneous inc and dec cancel; otherwise step in the guarded direction.
    always_comb begin
        cnt_next = cnt;
        if (inc && !dec_ok && !is_max) begin
            cnt_next = cnt + CNTW'(1);
        end else if (dec_ok && !inc) begin
            cnt_next = cnt - CNTW'(1);
        end
    end

    assign next_zero = (cnt_next == '0);

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// Register-file hazard controller: per-register in-flight write tracking,
// issue stall, same-cycle writeback bypass and a drain sequence for flush.
//
//  state | meaning
//  RUN   | normal issue; drain_req moves to DRAIN on the next edge
//  DRAIN | all issue stalled; leaves when every counter goes to zero,
//        | pulsing drain_done on the way out
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int CNTW      = 2,
    parameter bit BYPASS_EN = 1'b1
) (
    input logic            clk,
    input logic            rst,
    rf_scoreboard_if.slave sb
);

    sb_state_e       state;
    sb_state_e       state_next;
    logic            drain_done_next;

    logic [SELW-1:0] ra;
    logic [SELW-1:0] rb;
    logic            byp_a;
    logic            byp_b;
    logic            haz_a;
    logic            haz_b;
    logic            sat;
    logic            stall_int;
    logic            ack_int;

    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic [NREG-1:0] cnt_zero;
    logic [NREG-1:0] cnt_one;
    logic [NREG-1:0] cnt_max;
    logic [NREG-1:0] cnt_next_zero;

    logic            unused_ir;

    assign ra        = ra_field(sb.from_ir);
    assign rb        = rb_field(sb.from_ir);
    assign unused_ir = ^{sb.from_ir[15:14], sb.from_ir[7:0]};

    // Hazard, saturation and bypass decision for the instruction at issue.
    always_comb begin
        byp_a     = BYPASS_EN & sb.wb_valid & (sb.wb_sel == ra) & cnt_one[ra];
        byp_b     = BYPASS_EN & sb.wb_valid & (sb.wb_sel == rb) & cnt_one[rb];
        haz_a     = sb.use_ra & ~cnt_zero[ra] & ~byp_a;
        haz_b     = sb.use_rb & ~cnt_zero[rb] & ~byp_b;
        // A full counter can still take a new writer if it retires one this cycle.
        sat       = sb.wr_en & cnt_max[sb.wr_sel] &
                    ~(sb.wb_valid & (sb.wb_sel == sb.wr_sel));
        stall_int = sb.issue_valid & (haz_a | haz_b | sat | (state == DRAIN));
        ack_int   = sb.issue_valid & ~stall_int;
    end

    assign sb.stall     = stall_int;
    assign sb.issue_ack = ack_int;
    assign sb.fwd_ra    = ack_int & sb.use_ra & byp_a;
    assign sb.fwd_rb    = ack_int & sb.use_rb & byp_b;
    assign sb.busy_mask = ~cnt_zero;

    // Per-register increment on accepted writer, decrement on writeback.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 0; r < NREG; r++) begin
            inc[r] = ack_int & sb.wr_en & (sb.wr_sel == SELW'(r));
            dec[r] = sb.wb_valid & (sb.wb_sel == SELW'(r));
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        rf_sb_counter #(.CNTW(CNTW)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .is_zero   (cnt_zero[r]),
            .is_one    (cnt_one[r]),
            .is_max    (cnt_max[r]),
            .next_zero (cnt_next_zero[r])
        );
    end

    // Drain FSM next state; completion is judged on the post-edge counts.
    always_comb begin
        state_next      = state;
        drain_done_next = 1'b0;
        case (state)
            RUN: begin
                if (sb.drain_req) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (&cnt_next_zero) begin
                    state_next      = RUN;
                    drain_done_next = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // FSM state, drain_done pulse and sticky writeback error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            sb.drain_done <= 1'b0;
            sb.wb_err     <= 1'b0;
        end else begin
            state         <= state_next;
            sb.drain_done <= drain_done_next;
            if (sb.wb_valid && cnt_zero[sb.wb_sel]) begin
                sb.wb_err <= 1'b1;
            end
        end
    end

endmodule
